// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci job scheduler: FSM state encoding
// and the engine's starting pair F(0), F(1).
package fib_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int F_INIT_A = 0;
    localparam int F_INIT_B = 1;

endpackage

// File: rtl/fib_job_scheduler_engine.sv
// Iterative Fibonacci step engine: holds the (a, b) pair, advances one
// step when asked, and remembers whether any step carried out of WIDTH bits.
module fib_step_engine
    import fib_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_a,
    output logic             o_ovf
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_ovf;
    logic [WIDTH:0]   w_sum;

    // Full-width sum so the carry out is visible for the sticky flag.
    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    // Load the starting pair, or step a<=b, b<=a+b; carries are sticky until the next load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_ovf <= 1'b0;
        end else if (i_load) begin
            r_a   <= WIDTH'(F_INIT_A);
            r_b   <= WIDTH'(F_INIT_B);
            r_ovf <= 1'b0;
        end else if (i_step) begin
            r_a <= r_b;
            r_b <= w_sum[WIDTH-1:0];
            if (w_sum[WIDTH]) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_a   = r_a;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/fib_job_scheduler.sv
// Round-robin scheduler sharing one Fibonacci step engine among NREQ
// requesters. Handshakes: a transfer happens on a rising edge where both
// valid and ready are high; requesters hold valid/idx until ready, and the
// response (valid/id/value/ovf) is held stable until rsp_ready.
module fib_job_scheduler
    import fib_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int ID_W     = 2,
    parameter int WIDTH    = 16,
    parameter int IDX_W    = 5,
    parameter int STEP_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*IDX_W-1:0] req_idx,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [WIDTH-1:0]      rsp_value,
    output logic                  rsp_ovf,
    input  logic                  rsp_ready,
    output logic                  busy
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ID_W-1:0]  r_rr;
    logic [ID_W-1:0]  r_id;
    logic [IDX_W-1:0] r_rem;
    logic [DIV_W-1:0] r_div;

    logic             w_any_valid;
    logic [ID_W-1:0]  w_gnt_id;
    logic [IDX_W-1:0] w_gnt_idx;
    logic             w_div_last;
    logic             w_load;
    logic             w_step;
    logic [WIDTH-1:0] w_a;
    logic             w_ovf;

    // Pick the first valid requester after the round-robin pointer, wrapping around.
    always_comb begin
        int k;
        k           = 0;
        w_any_valid = 1'b0;
        w_gnt_id    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            k = int'(r_rr) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (!w_any_valid && req_valid[k]) begin
                w_any_valid = 1'b1;
                w_gnt_id    = ID_W'(k);
            end
        end
    end

    // Select the granted requester's index from the packed bus.
    always_comb begin
        w_gnt_idx = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_gnt_id == ID_W'(j)) begin
                w_gnt_idx = req_idx[j*IDX_W +: IDX_W];
            end
        end
    end

    assign w_div_last = (r_div == DIV_W'(STEP_DIV - 1));

    // Next-state and control decode; req_ready is held low while reset is asserted.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        req_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_valid && reset) begin
                    req_ready   = NREQ'(1) << w_gnt_id;
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_rem == '0) begin
                    w_state_nxt = ST_RESP;
                end else if (w_div_last) begin
                    w_step = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Job bookkeeping: capture the grant, then pace steps with the divider and count them down.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr  <= ID_W'(NREQ - 1);
            r_id  <= '0;
            r_rem <= '0;
            r_div <= '0;
        end else if (w_load) begin
            r_rr  <= w_gnt_id;
            r_id  <= w_gnt_id;
            r_rem <= w_gnt_idx;
            r_div <= '0;
        end else if (r_state == ST_RUN && r_rem != '0) begin
            if (w_div_last) begin
                r_div <= '0;
                r_rem <= r_rem - IDX_W'(1);
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    fib_step_engine #(
        .WIDTH (WIDTH)
    ) u_engine (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_step (w_step),
        .o_a    (w_a),
        .o_ovf  (w_ovf)
    );

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_id    = r_id;
    assign rsp_value = w_a;
    assign rsp_ovf   = w_ovf;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fib_job_scheduler.sv
// Bench for fib_job_scheduler: transaction-level model (true Fibonacci
// values, round-robin grant, latency rule) checked every cycle, plus a
// table of hand-computed results and directed multi-cycle sequences.
module tb_fib_job_scheduler;

    localparam int NREQ     = 4;
    localparam int ID_W     = 2;
    localparam int WIDTH    = 16;
    localparam int IDX_W    = 5;
    localparam int STEP_DIV = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*IDX_W-1:0] req_idx;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [WIDTH-1:0]      rsp_value;
    logic                  rsp_ovf;
    logic                  rsp_ready;
    logic                  busy;

    fib_job_scheduler #(
        .NREQ(NREQ), .ID_W(ID_W), .WIDTH(WIDTH), .IDX_W(IDX_W), .STEP_DIV(STEP_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_value (rsp_value),
        .rsp_ovf   (rsp_ovf),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        int               id;
        logic [WIDTH-1:0] value;
        logic             ovf;
        int               due;
    } exp_t;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] value;
        logic             ovf;
    } rsp_t;

    exp_t            exp_q[$];
    rsp_t            rsp_log[$];
    int              grant_log[$];

    int              n_checks = 0;
    int              n_pass   = 0;
    int              cyc      = 0;
    logic [NREQ-1:0] pend_valid;
    int              pend_idx[NREQ];
    bit              rearm;
    logic            rsp_ready_drv;
    int              model_ptr;
    bit              model_busy;
    bit              prev_rsp_valid;
    int              last_acc_cyc;
    int              last_hs_cyc;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic longint fib_true(input int n);
        longint x, y, t;
        x = 0;
        y = 1;
        for (int i = 0; i < n; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int model_grant();
        int k;
        for (int i = 1; i <= NREQ; i++) begin
            k = (model_ptr + i) % NREQ;
            if (pend_valid[k]) return k;
        end
        return -1;
    endfunction

    // ---------------- driver / monitor: one clock cycle ----------------
    task automatic step();
        int   g;
        bit   acc;
        bit   hs;
        exp_t e;
        rsp_t r;
        g   = 0;
        acc = 0;
        hs  = 0;
        req_valid = pend_valid;
        for (int k = 0; k < NREQ; k++) req_idx[k*IDX_W +: IDX_W] = IDX_W'(pend_idx[k]);
        rsp_ready = rsp_ready_drv;
        @(negedge clk);
        check("busy", busy, model_busy);
        if (model_busy) begin
            if (pend_valid != 0) check("req_ready_while_busy", req_ready, 0);
        end else if (pend_valid != 0) begin
            g = model_grant();
            check("grant", req_ready, longint'(1) << g);
            acc     = 1;
            e.id    = g;
            e.value = WIDTH'(fib_true(pend_idx[g]));
            e.ovf   = (fib_true(pend_idx[g] + 1) >= (longint'(1) << WIDTH));
            e.due   = cyc + 2 + pend_idx[g] * STEP_DIV;
            exp_q.push_back(e);
            model_ptr = g;
            grant_log.push_back(g);
            last_acc_cyc = cyc;
        end else begin
            check("req_ready_idle", req_ready, 0);
        end
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_rsp", 1, 0);
            end else begin
                if (!prev_rsp_valid) check("latency", cyc, exp_q[0].due);
                check("rsp_id", rsp_id, exp_q[0].id);
                check("rsp_value", rsp_value, exp_q[0].value);
                check("rsp_ovf", rsp_ovf, exp_q[0].ovf);
                if (rsp_ready) begin
                    hs      = 1;
                    r.id    = int'(rsp_id);
                    r.value = rsp_value;
                    r.ovf   = rsp_ovf;
                    rsp_log.push_back(r);
                    void'(exp_q.pop_front());
                    last_hs_cyc = cyc;
                end
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
            check("rsp_overdue", cyc, exp_q[0].due);
            void'(exp_q.pop_front());
        end
        prev_rsp_valid = rsp_valid && !hs;
        @(posedge clk);
        cyc++;
        if (acc) begin
            model_busy = 1;
            if (!rearm) pend_valid[g] = 1'b0;
        end
        if (hs) model_busy = 0;
        #1;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || pend_valid != 0 || model_busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            check("drain_timeout", n, -1);
            exp_q.delete();
            pend_valid = '0;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        pend_valid = '0;
        rearm      = 0;
        rsp_ready_drv = 1'b1;
        rsp_ready  = 1'b1;
        req_valid  = '1;
        req_idx    = '0;
        #1;
        check("reset_rsp_valid_now", rsp_valid, 0);
        check("reset_busy_now", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_value", rsp_value, 0);
        check("reset_rsp_ovf", rsp_ovf, 0);
        check("reset_req_ready", req_ready, 0);
        check("reset_busy", busy, 0);
        exp_q.delete();
        model_busy     = 0;
        model_ptr      = NREQ - 1;
        prev_rsp_valid = 0;
        req_valid      = '0;
        reset          = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int               id;
        int               n;
        logic [WIDTH-1:0] value;
        logic             ovf;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int n;
        vecs[0] = '{0, 10, 16'd55,    1'b0};
        vecs[1] = '{2, 0,  16'd0,     1'b0};
        vecs[2] = '{2, 1,  16'd1,     1'b0};
        vecs[3] = '{1, 24, 16'd46368, 1'b1};   // final b = 75025 carries
        vecs[4] = '{3, 25, 16'd9489,  1'b1};
        vecs[5] = '{0, 20, 16'd6765,  1'b0};
        vecs[6] = '{1, 2,  16'd1,     1'b0};
        vecs[7] = '{3, 5,  16'd5,     1'b0};
        vecs[8] = '{2, 31, 16'd35549, 1'b1};

        for (int k = 0; k < NREQ; k++) pend_idx[k] = 0;
        last_acc_cyc = 0;
        last_hs_cyc  = 0;
        do_reset();

        // Single jobs against hand-computed results.
        for (int v = 0; v < 9; v++) begin
            rsp_log.delete();
            pend_valid[vecs[v].id] = 1'b1;
            pend_idx[vecs[v].id]   = vecs[v].n;
            run_until_idle(300);
            check("tbl_count", rsp_log.size(), 1);
            if (rsp_log.size() > 0) begin
                check("tbl_id", rsp_log[0].id, vecs[v].id);
                check("tbl_value", rsp_log[0].value, vecs[v].value);
                check("tbl_ovf", rsp_log[0].ovf, vecs[v].ovf);
            end
        end

        // Back-pressure: rsp_ready low for 10 RESP cycles with another request waiting.
        pend_valid[3] = 1'b1;
        pend_idx[3]   = 4;
        step();
        pend_valid[1] = 1'b1;
        pend_idx[1]   = 2;
        rsp_ready_drv = 1'b0;
        n = 0;
        while (!prev_rsp_valid && n < 100) begin
            step();
            n++;
        end
        check("bp_reached_resp", prev_rsp_valid, 1);
        repeat (9) step();
        rsp_ready_drv = 1'b1;
        step();
        step();
        check("bp_next_accept_cycle", last_acc_cyc, last_hs_cyc + 1);
        check("bp_next_grant", grant_log[grant_log.size()-1], 1);
        run_until_idle(200);

        // Continuous requests from everyone: grants 0,1,2,3,0.
        do_reset();
        grant_log.delete();
        rsp_log.delete();
        rearm = 1;
        for (int k = 0; k < NREQ; k++) begin
            pend_valid[k] = 1'b1;
            pend_idx[k]   = 3;
        end
        n = 0;
        while (grant_log.size() < 5 && n < 300) begin
            step();
            n++;
        end
        rearm      = 0;
        pend_valid = '0;
        run_until_idle(200);
        check("rr_grant_count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) check("rr_grant_order", grant_log[i], i % NREQ);
        for (int i = 0; i < rsp_log.size(); i++) check("rr_value", rsp_log[i].value, 2);

        // Reset in the middle of a long job, then requester 0 wins first again.
        pend_valid[1] = 1'b1;
        pend_idx[1]   = 20;
        repeat (30) step();
        check("mid_run_busy_model", model_busy, 1);
        do_reset();
        rsp_log.delete();
        grant_log.delete();
        pend_valid[0] = 1'b1;
        pend_idx[0]   = 20;
        pend_valid[1] = 1'b1;
        pend_idx[1]   = 20;
        run_until_idle(400);
        check("post_reset_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        check("post_reset_rsp_count", rsp_log.size(), 2);
        if (rsp_log.size() > 0) begin
            check("post_reset_id", rsp_log[0].id, 0);
            check("post_reset_value", rsp_log[0].value, 6765);
        end

        // Randomized traffic with withdrawals and random back-pressure.
        for (int t = 0; t < 1500; t++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!pend_valid[k] && $urandom_range(0, 9) == 0) begin
                    pend_valid[k] = 1'b1;
                    pend_idx[k]   = $urandom_range(0, 12);
                end else if (pend_valid[k] && $urandom_range(0, 49) == 0) begin
                    pend_valid[k] = 1'b0;
                end
            end
            rsp_ready_drv = ($urandom_range(0, 3) != 0);
            step();
        end
        pend_valid    = '0;
        rsp_ready_drv = 1'b1;
        run_until_idle(300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
